// File: rtl/regfile_wb_merge.sv
// Write-back merge stage feeding the register file write port: the in-order
// pipeline always wins, late multi-cycle results queue in a FIFO and drain on idle cycles.
// Optional same-cycle bypass of late results into an idle, empty stage: define WB_BYPASS_EN.
module regfile_wb_merge #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          p_we,
  input  logic [4:0]    p_wn,
  input  logic [31:0]   p_d,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [4:0]    s_wn,
  input  logic [31:0]   s_d,
  input  logic [4:0]    rna,
  input  logic [4:0]    rnb,
  output logic          pend_a,
  output logic          pend_b,
  output logic          we,
  output logic [4:0]    wn,
  output logic [31:0]   d,
  output logic [AW:0]   count
);

  logic [AW:0]      cnt;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [DEPTH-1:0] ent_vld;
  logic [4:0]       ent_wn [DEPTH];
  logic [31:0]      ent_d  [DEPTH];

  logic p_act;
  logic not_empty;
  logic head_vld;
  logic byp_take;
  logic push;
  logic push_wr;
  logic pop;

  // A pipeline write to r0 is no write at all; the FIFO may drain in its place.
  assign p_act     = p_we && (p_wn != 5'd0);
  assign not_empty = (cnt != '0);
  assign head_vld  = ent_vld[rd_ptr];
  assign count     = cnt;

  // Ready comes from registered occupancy only, so a full FIFO refuses even while popping.
  assign s_ready = clrn && (cnt < (AW+1)'(DEPTH));

`ifdef WB_BYPASS_EN
  assign byp_take = clrn && !not_empty && !p_act && s_valid && (s_wn != 5'd0);
`else
  assign byp_take = 1'b0;
`endif

  assign push    = s_valid && s_ready;
  assign push_wr = push && (s_wn != 5'd0) && !byp_take;
  assign pop     = clrn && !p_act && not_empty;

  // Write port mux; address and data are held at zero whenever no write is issued.
  always_comb begin
    // NOTE: every output gets a default before the priority chain so no latch is inferred.
    we = 1'b0;
    wn = 5'd0;
    d  = 32'd0;
    if (clrn) begin
      if (p_act) begin
        we = 1'b1;
        wn = p_wn;
        d  = p_d;
      end else if (byp_take) begin
        we = 1'b1;
        wn = s_wn;
        d  = s_d;
      end else if (not_empty && head_vld) begin
        we = 1'b1;
        wn = ent_wn[rd_ptr];
        d  = ent_d[rd_ptr];
      end
    end
  end

  // Only occupied, unkilled slots carry vld=1, so no occupancy mask is needed here.
  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_wn[i] == rna)) pend_a = 1'b1;
      if (ent_vld[i] && (ent_wn[i] == rnb)) pend_b = 1'b1;
    end
    pend_a = pend_a && clrn && (rna != 5'd0);
    pend_b = pend_b && clrn && (rnb != 5'd0);
  end

  // Control state: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      ent_vld <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; later writes below override earlier ones.
      for (int i = 0; i < DEPTH; i++) begin
        if (p_act && (ent_wn[i] == p_wn)) ent_vld[i] <= 1'b0;
        if (pop && (rd_ptr == AW'(i)))    ent_vld[i] <= 1'b0;
        if (push_wr && (wr_ptr == AW'(i))) ent_vld[i] <= 1'b1;
      end
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_wr) wr_ptr <= wr_ptr + 1'b1;
      case ({push_wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: payload storage has no reset; it is only observed through a set vld bit.
  always_ff @(posedge clk) begin
    if (clrn && push_wr) begin
      ent_wn[wr_ptr] <= s_wn;
      ent_d[wr_ptr]  <= s_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_merge.sv
// Self-checking bench for regfile_wb_merge: directed scenarios plus random traffic,
// all compared each cycle against a queue-based model of the merge rules.
module tb_regfile_wb_merge;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          clrn;
  logic          p_we;
  logic [4:0]    p_wn;
  logic [31:0]   p_d;
  logic          s_valid;
  logic          s_ready;
  logic [4:0]    s_wn;
  logic [31:0]   s_d;
  logic [4:0]    rna;
  logic [4:0]    rnb;
  logic          pend_a;
  logic          pend_b;
  logic          we;
  logic [4:0]    wn;
  logic [31:0]   d;
  logic [AW:0]   count;

  regfile_wb_merge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .clrn(clrn),
    .p_we(p_we), .p_wn(p_wn), .p_d(p_d),
    .s_valid(s_valid), .s_ready(s_ready), .s_wn(s_wn), .s_d(s_d),
    .rna(rna), .rnb(rnb), .pend_a(pend_a), .pend_b(pend_b),
    .we(we), .wn(wn), .d(d), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        vld;
    bit [4:0]  wn;
    bit [31:0] d;
  } ent_t;

  ent_t q[$];
  bit   known = 0;
  int   total = 0;
  int   bad   = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, exp);
    end
  endtask

  function automatic bit pending(input bit [4:0] r);
    pending = 1'b0;
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].vld && q[i].wn == r) pending = 1'b1;
  endfunction

  // One clock cycle: apply inputs, compare against the model, then advance the model at the edge.
  task automatic step(input bit c, input bit pwe, input bit [4:0] pwn, input bit [31:0] pd,
                      input bit sv, input bit [4:0] swn, input bit [31:0] sd,
                      input bit [4:0] ra, input bit [4:0] rb);
    bit        e_we, e_rdy, p_act, byp, do_pop, do_push;
    bit [4:0]  e_wn;
    bit [31:0] e_d;
    clrn = c; p_we = pwe; p_wn = pwn; p_d = pd;
    s_valid = sv; s_wn = swn; s_d = sd; rna = ra; rnb = rb;
    #3;
    p_act  = pwe && pwn != 0;
    e_rdy  = c && known && q.size() < DEPTH;
    byp    = BYPASS && c && known && q.size() == 0 && !p_act && sv && swn != 0;
    do_pop = c && !p_act && q.size() > 0;
    e_we = 0; e_wn = 0; e_d = 0;
    if (c) begin
      if (p_act)                        begin e_we = 1; e_wn = pwn;     e_d = pd;     end
      else if (byp)                     begin e_we = 1; e_wn = swn;     e_d = sd;     end
      else if (q.size() > 0 && q[0].vld) begin e_we = 1; e_wn = q[0].wn; e_d = q[0].d; end
    end
    check("we", 64'(we), 64'(e_we));
    check("wn", 64'(wn), 64'(e_wn));
    check("d", 64'(d), 64'(e_d));
    check("s_ready", 64'(s_ready), 64'(e_rdy));
    check("pend_a", 64'(pend_a), 64'(c && pending(ra)));
    check("pend_b", 64'(pend_b), 64'(c && pending(rb)));
    if (known) check("count", 64'(count), 64'(q.size()));
    do_push = sv && e_rdy && swn != 0 && !byp;
    @(posedge clk);
    if (!c) begin
      q.delete();
      known = 1;
    end else begin
      if (p_act) foreach (q[i]) if (q[i].wn == pwn) q[i].vld = 0;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{vld: 1'b1, wn: swn, d: sd});
    end
    #1;
  endtask

  task automatic idle(input int n, input bit [4:0] ra);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, ra, 0);
  endtask

  initial begin
    clrn = 0; p_we = 0; p_wn = 0; p_d = 0; s_valid = 0; s_wn = 0; s_d = 0; rna = 0; rnb = 0;
    #1;
    // Reset held with live requests on both sources.
    step(0, 1, 5'd3, 32'h1234, 1, 5'd4, 32'h5678, 5'd4, 5'd3);
    step(0, 1, 5'd3, 32'h1234, 1, 5'd4, 32'h5678, 5'd4, 5'd3);
    idle(1, 0);

    // Drain of a single late result, pending visible until commit.
    step(1, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 0);
    idle(2, 5'd5);

    // Pipeline priority over a queued entry.
    step(1, 1, 5'd9, 32'h1, 1, 5'd7, 32'h11, 5'd7, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 5'd3, 32'h22, 0, 0, 0, 5'd7, 5'd3);
    idle(2, 5'd7);

    // Fill to full under a busy pipeline, fifth push refused, then drain in order.
    for (int i = 1; i <= 5; i++) step(1, 1, 5'd9, 32'h99, 1, 5'(i), 32'(i * 16), 5'(i), 0);
    step(1, 1, 5'd9, 32'h99, 1, 5'd6, 32'h66, 5'd1, 5'd4);
    idle(6, 5'd4);

    // WAW kill: pipeline overwrites a queued register.
    step(1, 1, 5'd9, 32'h1, 1, 5'd8, 32'hAA, 5'd8, 0);
    step(1, 1, 5'd8, 32'hBB, 0, 0, 0, 5'd8, 0);
    idle(3, 5'd8);

    // Late result to r0 is swallowed; pipeline write to r0 lets the FIFO drain.
    step(1, 0, 0, 0, 1, 5'd0, 32'h77, 0, 0);
    step(1, 1, 5'd9, 32'h1, 1, 5'd6, 32'h66, 5'd6, 0);
    step(1, 1, 5'd0, 32'h2, 0, 0, 0, 5'd6, 0);
    idle(2, 5'd6);

    // Reset mid-operation with entries queued.
    for (int i = 0; i < 3; i++) step(1, 1, 5'd2, 32'h3, 1, 5'(10 + i), 32'(i), 5'd10, 5'd11);
    step(0, 0, 0, 0, 0, 0, 0, 5'd10, 5'd11);
    idle(3, 5'd10);

    // Random traffic with busy/quiet phases and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      bit busy;
      busy = ((n / 64) % 2) == 0;
      step(($urandom_range(0, 199) != 0),
           busy ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2),
           5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
